// File: rtl/lru_replace_unit_if.sv
// lru_replace_unit_if: hit report bus and per-set victim outputs of the LRU tracker
interface lru_replace_unit_if #(
    parameter int WAY_NUM     = 4,
    parameter int INDEX_WIDTH = 4
);
    logic [WAY_NUM-1:0]     hit_en;
    logic [INDEX_WIDTH-1:0] index;
    logic [2:0] line0_replace_way,  line1_replace_way,  line2_replace_way,  line3_replace_way;
    logic [2:0] line4_replace_way,  line5_replace_way,  line6_replace_way,  line7_replace_way;
    logic [2:0] line8_replace_way,  line9_replace_way,  line10_replace_way, line11_replace_way;
    logic [2:0] line12_replace_way, line13_replace_way, line14_replace_way, line15_replace_way;

    modport master (
        output hit_en, index,
        input  line0_replace_way,  line1_replace_way,  line2_replace_way,  line3_replace_way,
               line4_replace_way,  line5_replace_way,  line6_replace_way,  line7_replace_way,
               line8_replace_way,  line9_replace_way,  line10_replace_way, line11_replace_way,
               line12_replace_way, line13_replace_way, line14_replace_way, line15_replace_way
    );

    modport slave (
        input  hit_en, index,
        output line0_replace_way,  line1_replace_way,  line2_replace_way,  line3_replace_way,
               line4_replace_way,  line5_replace_way,  line6_replace_way,  line7_replace_way,
               line8_replace_way,  line9_replace_way,  line10_replace_way, line11_replace_way,
               line12_replace_way, line13_replace_way, line14_replace_way, line15_replace_way
    );
endinterface

// File: rtl/lru_replace_unit.sv
// lru_replace_unit: true-LRU age tracker for a 4-way, 16-set cache, presenting each set's victim way
module lru_replace_unit #(
    parameter int WAY_NUM     = 4,
    parameter int INDEX_WIDTH = 4,
    parameter int AGE_WIDTH   = 2
) (
    input logic                clk,
    input logic                rst_n,
    lru_replace_unit_if.slave  bus
);
    localparam int SETS = 2 ** INDEX_WIDTH;

    logic [AGE_WIDTH-1:0] age_q [SETS][WAY_NUM];
    logic [AGE_WIDTH-1:0] age_d [SETS][WAY_NUM];
    logic [AGE_WIDTH-1:0] victim [SETS];
    logic [AGE_WIDTH-1:0] hit_age;
    logic                 one_hot;

    assign one_hot = (bus.hit_en != '0) && ((bus.hit_en & (bus.hit_en - 1'b1)) == '0);

    // Promote the hit way to age 0 and age every younger way in the addressed set by one
    always_comb begin
        age_d   = age_q;
        hit_age = '0;
        for (int w = 0; w < WAY_NUM; w++)
            if (bus.hit_en[w]) hit_age = age_q[bus.index][w];
        if (one_hot)
            for (int w = 0; w < WAY_NUM; w++)
                age_d[bus.index][w] = bus.hit_en[w] ? '0 :
                                      (age_q[bus.index][w] < hit_age) ? age_q[bus.index][w] + 1'b1 :
                                      age_q[bus.index][w];
    end

    // Age state; reset orders every set with way 0 oldest and way 3 newest
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAY_NUM; w++)
                    age_q[s][w] <= AGE_WIDTH'(WAY_NUM - 1 - w);
        end else begin
            age_q <= age_d;
        end
    end

    // Victim is the lowest-numbered way holding the oldest age, 0 when none does
    always_comb begin
        for (int s = 0; s < SETS; s++) begin
            victim[s] = '0;
            for (int w = WAY_NUM - 1; w >= 0; w--)
                if (age_q[s][w] == AGE_WIDTH'(WAY_NUM - 1)) victim[s] = AGE_WIDTH'(w);
        end
    end

    assign bus.line0_replace_way  = {1'b0, victim[0]};
    assign bus.line1_replace_way  = {1'b0, victim[1]};
    assign bus.line2_replace_way  = {1'b0, victim[2]};
    assign bus.line3_replace_way  = {1'b0, victim[3]};
    assign bus.line4_replace_way  = {1'b0, victim[4]};
    assign bus.line5_replace_way  = {1'b0, victim[5]};
    assign bus.line6_replace_way  = {1'b0, victim[6]};
    assign bus.line7_replace_way  = {1'b0, victim[7]};
    assign bus.line8_replace_way  = {1'b0, victim[8]};
    assign bus.line9_replace_way  = {1'b0, victim[9]};
    assign bus.line10_replace_way = {1'b0, victim[10]};
    assign bus.line11_replace_way = {1'b0, victim[11]};
    assign bus.line12_replace_way = {1'b0, victim[12]};
    assign bus.line13_replace_way = {1'b0, victim[13]};
    assign bus.line14_replace_way = {1'b0, victim[14]};
    assign bus.line15_replace_way = {1'b0, victim[15]};
endmodule

// File: tb/tb_lru_replace_unit.sv
// tb_lru_replace_unit: directed table, recency-list reference model with random hits, and async reset checks
module tb_lru_replace_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lru_replace_unit_if bus ();
    lru_replace_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [2:0] lines [16];
    assign lines[0]  = bus.line0_replace_way;
    assign lines[1]  = bus.line1_replace_way;
    assign lines[2]  = bus.line2_replace_way;
    assign lines[3]  = bus.line3_replace_way;
    assign lines[4]  = bus.line4_replace_way;
    assign lines[5]  = bus.line5_replace_way;
    assign lines[6]  = bus.line6_replace_way;
    assign lines[7]  = bus.line7_replace_way;
    assign lines[8]  = bus.line8_replace_way;
    assign lines[9]  = bus.line9_replace_way;
    assign lines[10] = bus.line10_replace_way;
    assign lines[11] = bus.line11_replace_way;
    assign lines[12] = bus.line12_replace_way;
    assign lines[13] = bus.line13_replace_way;
    assign lines[14] = bus.line14_replace_way;
    assign lines[15] = bus.line15_replace_way;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: per set, ways listed from most to least recently used
    int order [16][4];

    function automatic void model_reset();
        for (int s = 0; s < 16; s++)
            for (int k = 0; k < 4; k++) order[s][k] = 3 - k;
    endfunction

    function automatic void model_hit(logic [3:0] h, logic [3:0] i);
        int w = 0;
        int p = 0;
        if ($countones(h) != 1) return;
        for (int k = 0; k < 4; k++) if (h[k]) w = k;
        for (int k = 0; k < 4; k++) if (order[i][k] == w) p = k;
        for (int k = p; k > 0; k--) order[i][k] = order[i][k-1];
        order[i][0] = w;
    endfunction

    function automatic logic [2:0] model_victim(int s);
        return 3'(order[s][3]);
    endfunction

    task automatic check(string name, logic [2:0] act, logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(string tag);
        for (int s = 0; s < 16; s++)
            check($sformatf("%s line%0d", tag, s), lines[s], model_victim(s));
    endtask

    task automatic step(logic [3:0] h, logic [3:0] i);
        @(negedge clk);
        bus.hit_en = h;
        bus.index  = i;
        @(posedge clk);
        model_hit(h, i);
        #1;
    endtask

    typedef struct {
        logic [3:0] h;
        logic [3:0] idx;
        int         chk;
        logic [2:0] exp;
    } vec_t;

    vec_t tbl [21];

    initial begin
        tbl[0]  = '{4'b0001, 4'd0, 0, 3'd1};
        tbl[1]  = '{4'b0010, 4'd0, 0, 3'd2};
        tbl[2]  = '{4'b0100, 4'd0, 0, 3'd3};
        tbl[3]  = '{4'b0010, 4'd0, 0, 3'd3};
        tbl[4]  = '{4'b1000, 4'd2, 2, 3'd0};
        tbl[5]  = '{4'b0100, 4'd2, 2, 3'd0};
        tbl[6]  = '{4'b0010, 4'd2, 2, 3'd0};
        tbl[7]  = '{4'b0010, 4'd2, 2, 3'd0};
        tbl[8]  = '{4'b0001, 4'd2, 2, 3'd3};
        tbl[9]  = '{4'b0001, 4'd1, 1, 3'd1};
        tbl[10] = '{4'b1000, 4'd1, 1, 3'd1};
        tbl[11] = '{4'b0000, 4'd1, 1, 3'd1};
        tbl[12] = '{4'b0110, 4'd1, 1, 3'd1};
        tbl[13] = '{4'b0001, 4'd5, 5, 3'd1};
        tbl[14] = '{4'b0001, 4'd9, 9, 3'd1};
        tbl[15] = '{4'b0010, 4'd5, 5, 3'd2};
        tbl[16] = '{4'b0010, 4'd9, 9, 3'd2};
        tbl[17] = '{4'b0100, 4'd5, 5, 3'd3};
        tbl[18] = '{4'b0100, 4'd9, 9, 3'd3};
        tbl[19] = '{4'b1111, 4'd9, 9, 3'd3};
        tbl[20] = '{4'b0000, 4'd5, 5, 3'd3};

        bus.hit_en = '0;
        bus.index  = '0;
        model_reset();
        #12 rst_n = 1'b1;
        #1 check_all("reset");

        for (int v = 0; v < 21; v++) begin
            step(tbl[v].h, tbl[v].idx);
            check($sformatf("vec%0d line%0d", v, tbl[v].chk), lines[tbl[v].chk], tbl[v].exp);
        end
        check_all("after_table");

        for (int n = 0; n < 400; n++) begin
            int sel = int'($urandom_range(0, 5));
            logic [3:0] h;
            h = sel < 4 ? 4'(1 << sel) : sel == 4 ? 4'b0000 : 4'($urandom_range(0, 15));
            step(h, 4'($urandom_range(0, 15)));
            check_all($sformatf("rand%0d", n));
        end

        step(4'b0001, 4'd0);
        step(4'b0010, 4'd0);
        step(4'b0100, 4'd0);
        check("pre_reset line0", lines[0], 3'd3);
        @(negedge clk);
        bus.hit_en = '0;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check("async line0", lines[0], 3'd0);
        check_all("async");
        #1 rst_n = 1'b1;
        step(4'b0001, 4'd0);
        check("post_release line0", lines[0], 3'd1);
        check_all("post_release");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
